mem_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory bus between the instruction-fetch port and the data-access port of the mipsel32 core.
- Latches one requester's transaction and drives it downstream.
- Routes the address-accept and data-return handshakes back to the owner, with one outstanding transaction at a time.
- Sits between the pipeline's IF/MEM stages (data side already carries byte strobes from the store-enable logic) and the memory/cache bridge.

---
 rtl/mem_bus_arbiter_if.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: fetch port, data port and the shared downstream SRAM-like bus.
// master = arbiter view, slave = surrounding core/memory view.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    // Instruction-fetch port
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // Data-access port
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [STRB_W-1:0] data_wstrb;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // Downstream memory bus
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch and data ports, one outstanding transaction at a time.
// Define MEM_BUS_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    mem_bus_arbiter_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              owner;
    logic              any_req_c;
    logic              pick_data_c;
    logic              grant_c;

    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] wdata_q;

    logic              inst_addr_ok_c;
    logic              data_addr_ok_c;
    logic              inst_data_ok_c;
    logic              data_data_ok_c;

    assign any_req_c = bus.inst_req | bus.data_req;
    assign grant_c   = (state == ST_IDLE) & any_req_c;

`ifdef MEM_BUS_ARB_RR_EN
    logic last_grant;

    // On a tie, whichever side did not win the previous grant goes first.
    assign pick_data_c = bus.data_req & (~bus.inst_req | (last_grant == OWN_INST));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= OWN_INST;
        end else if (grant_c) begin
            last_grant <= pick_data_c;
        end
    end
`else
    assign pick_data_c = bus.data_req;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and owner-routed handshakes; stray addr_ok/data_ok outside their phase are ignored.
    always_comb begin
        state_nxt      = state;
        inst_addr_ok_c = 1'b0;
        data_addr_ok_c = 1'b0;
        inst_data_ok_c = 1'b0;
        data_data_ok_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req_c) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.addr_ok) begin
                    state_nxt      = ST_RESP;
                    inst_addr_ok_c = (owner == OWN_INST);
                    data_addr_ok_c = (owner == OWN_DATA);
                end
            end
            ST_RESP: begin
                if (bus.data_ok) begin
                    state_nxt      = ST_IDLE;
                    inst_data_ok_c = (owner == OWN_INST);
                    data_data_ok_c = (owner == OWN_DATA);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's transaction at grant; held stable until the next grant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner   <= OWN_INST;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if (grant_c) begin
            if (pick_data_c) begin
                owner   <= OWN_DATA;
                wr_q    <= bus.data_wr;
                size_q  <= bus.data_size;
                addr_q  <= bus.data_addr;
                wstrb_q <= bus.data_wr ? bus.data_wstrb : STRB_W'(0);
                wdata_q <= bus.data_wdata;
            end else begin
                owner   <= OWN_INST;
                wr_q    <= 1'b0;
                size_q  <= 2'd2;
                addr_q  <= bus.inst_addr;
                wstrb_q <= '0;
                wdata_q <= '0;
            end
        end
    end

    assign bus.req   = (state == ST_REQ);
    assign bus.wr    = wr_q;
    assign bus.size  = size_q;
    assign bus.addr  = addr_q;
    assign bus.wstrb = wstrb_q;
    assign bus.wdata = wdata_q;

    assign bus.inst_addr_ok = inst_addr_ok_c;
    assign bus.data_addr_ok = data_addr_ok_c;
    assign bus.inst_data_ok = inst_data_ok_c;
    assign bus.data_data_ok = data_data_ok_c;

    // Read data is mirrored to both ports; only the owner's data_ok qualifies it.
    assign bus.inst_rdata = bus.rdata;
    assign bus.data_rdata = bus.rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner sequences and a
// random phase against a transaction-queue reference model. Honours MEM_BUS_ARB_RR_EN.
module tb_mem_bus_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
`ifdef MEM_BUS_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [3:0]  exp_wstrb;
    } vec_t;

    typedef struct {
        logic        owner;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        accepted;
    } txn_t;

    logic clk;
    logic resetn;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[6];

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = '0;
        bus.data_wstrb = '0;
        bus.data_wdata = '0;
        bus.addr_ok    = 1'b0;
        bus.data_ok    = 1'b0;
        bus.rdata      = '0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " req"},          64'(bus.req),          64'(0));
        chk({tag, " inst_addr_ok"}, 64'(bus.inst_addr_ok), 64'(0));
        chk({tag, " data_addr_ok"}, 64'(bus.data_addr_ok), 64'(0));
        chk({tag, " inst_data_ok"}, 64'(bus.inst_data_ok), 64'(0));
        chk({tag, " data_data_ok"}, 64'(bus.data_data_ok), 64'(0));
    endtask

    task automatic check_zero(input string tag);
        check_quiet(tag);
        chk({tag, " addr"},       64'(bus.addr),       64'(0));
        chk({tag, " wr"},         64'(bus.wr),         64'(0));
        chk({tag, " size"},       64'(bus.size),       64'(0));
        chk({tag, " wstrb"},      64'(bus.wstrb),      64'(0));
        chk({tag, " wdata"},      64'(bus.wdata),      64'(0));
        chk({tag, " inst_rdata"}, 64'(bus.inst_rdata), 64'(0));
        chk({tag, " data_rdata"}, 64'(bus.data_rdata), 64'(0));
    endtask

    // One full transaction starting in an idle cycle with the request(s) already driven.
    task automatic serve(input logic exp_data, input logic [31:0] exp_addr, input logic [31:0] rd,
                         input logic keep, input string tag);
        settle();
        chk({tag, " idle req"}, 64'(bus.req), 64'(0));
        tick();
        settle();
        chk({tag, " req"},  64'(bus.req),  64'(1));
        chk({tag, " addr"}, 64'(bus.addr), 64'(exp_addr));
        bus.addr_ok = 1'b1;
        #1;
        chk({tag, " inst_addr_ok"}, 64'(bus.inst_addr_ok), 64'(!exp_data));
        chk({tag, " data_addr_ok"}, 64'(bus.data_addr_ok), 64'(exp_data));
        tick();
        bus.addr_ok = 1'b0;
        if (!keep) begin
            if (exp_data) bus.data_req = 1'b0;
            else          bus.inst_req = 1'b0;
        end
        bus.data_ok = 1'b1;
        bus.rdata   = rd;
        settle();
        chk({tag, " resp req"},     64'(bus.req),          64'(0));
        chk({tag, " inst_data_ok"}, 64'(bus.inst_data_ok), 64'(!exp_data));
        chk({tag, " data_data_ok"}, 64'(bus.data_data_ok), 64'(exp_data));
        chk({tag, " inst_rdata"},   64'(bus.inst_rdata),   64'(rd));
        chk({tag, " data_rdata"},   64'(bus.data_rdata),   64'(rd));
        tick();
        bus.data_ok = 1'b0;
    endtask

    task automatic apply_vec(input int i, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", i);
        bus.data_wr    = v.wr;
        bus.data_size  = v.size;
        bus.data_wstrb = v.wstrb;
        bus.data_wdata = v.wdata;
        if (v.is_data) begin
            bus.data_req  = 1'b1;
            bus.data_addr = v.addr;
        end else begin
            bus.inst_req  = 1'b1;
            bus.inst_addr = v.addr;
            bus.data_addr = ~v.addr;
        end
        settle();
        check_quiet({tag, " idle"});
        tick();
        settle();
        chk({tag, " req"},   64'(bus.req),   64'(1));
        chk({tag, " addr"},  64'(bus.addr),  64'(v.addr));
        chk({tag, " wr"},    64'(bus.wr),    64'(v.exp_wr));
        chk({tag, " size"},  64'(bus.size),  64'(v.exp_size));
        chk({tag, " wstrb"}, 64'(bus.wstrb), 64'(v.exp_wstrb));
        if (v.is_data) chk({tag, " wdata"}, 64'(bus.wdata), 64'(v.wdata));
        chk({tag, " early addr_ok"}, 64'({bus.inst_addr_ok, bus.data_addr_ok}), 64'(0));
        bus.addr_ok = 1'b1;
        #1;
        chk({tag, " inst_addr_ok"}, 64'(bus.inst_addr_ok), 64'(!v.is_data));
        chk({tag, " data_addr_ok"}, 64'(bus.data_addr_ok), 64'(v.is_data));
        tick();
        bus.addr_ok  = 1'b0;
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        bus.data_ok  = 1'b1;
        bus.rdata    = v.rdata;
        settle();
        chk({tag, " resp req"},     64'(bus.req),          64'(0));
        chk({tag, " inst_data_ok"}, 64'(bus.inst_data_ok), 64'(!v.is_data));
        chk({tag, " data_data_ok"}, 64'(bus.data_data_ok), 64'(v.is_data));
        chk({tag, " inst_rdata"},   64'(bus.inst_rdata),   64'(v.rdata));
        chk({tag, " data_rdata"},   64'(bus.data_rdata),   64'(v.rdata));
        tick();
        bus.data_ok = 1'b0;
        settle();
        check_quiet({tag, " done"});
        tick();
    endtask

    // Random traffic checked against a queue holding the single in-flight transaction.
    task automatic run_random(input int cycles);
        txn_t q[$];
        txn_t t;
        logic last_data = 1'b0;
        logic inst_acc  = 1'b0;
        logic data_acc  = 1'b0;
        logic exp_req, accept, respond, own, pick;
        string tag;
        for (int c = 0; c < cycles; c++) begin
            tag = $sformatf("rnd%0d", c);
            if (inst_acc) bus.inst_req = 1'b0;
            if (data_acc) bus.data_req = 1'b0;
            if (!bus.inst_req && $urandom_range(0, 2) == 0) begin
                bus.inst_req  = 1'b1;
                bus.inst_addr = $urandom;
            end
            if (!bus.data_req && $urandom_range(0, 2) == 0) begin
                bus.data_req   = 1'b1;
                bus.data_wr    = 1'($urandom_range(0, 1));
                bus.data_size  = 2'($urandom_range(0, 3));
                bus.data_addr  = $urandom;
                bus.data_wstrb = 4'($urandom_range(0, 15));
                bus.data_wdata = $urandom;
            end
            bus.addr_ok = ($urandom_range(0, 2) == 0);
            bus.data_ok = ($urandom_range(0, 2) == 0);
            bus.rdata   = $urandom;

            exp_req = (q.size() != 0) && !q[0].accepted;
            accept  = exp_req && bus.addr_ok;
            respond = (q.size() != 0) && q[0].accepted && bus.data_ok;
            own     = (q.size() != 0) ? q[0].owner : 1'b0;
            settle();
            chk({tag, " req"},          64'(bus.req),          64'(exp_req));
            chk({tag, " inst_addr_ok"}, 64'(bus.inst_addr_ok), 64'(accept && !own));
            chk({tag, " data_addr_ok"}, 64'(bus.data_addr_ok), 64'(accept && own));
            chk({tag, " inst_data_ok"}, 64'(bus.inst_data_ok), 64'(respond && !own));
            chk({tag, " data_data_ok"}, 64'(bus.data_data_ok), 64'(respond && own));
            chk({tag, " rdata"}, 64'({bus.inst_rdata, bus.data_rdata}), 64'({bus.rdata, bus.rdata}));
            if (exp_req) begin
                chk({tag, " addr"},  64'(bus.addr),  64'(q[0].addr));
                chk({tag, " wr"},    64'(bus.wr),    64'(q[0].wr));
                chk({tag, " size"},  64'(bus.size),  64'(q[0].size));
                chk({tag, " wstrb"}, 64'(bus.wstrb), 64'(q[0].wstrb));
                if (own) chk({tag, " wdata"}, 64'(bus.wdata), 64'(q[0].wdata));
            end

            inst_acc = accept && !own;
            data_acc = accept && own;
            if (accept) begin
                q[0].accepted = 1'b1;
            end else if (respond) begin
                void'(q.pop_front());
            end else if (q.size() == 0 && (bus.inst_req || bus.data_req)) begin
                pick = bus.data_req && (!bus.inst_req || !(RR_MODE && last_data));
                last_data = pick;
                t.owner    = pick;
                t.accepted = 1'b0;
                if (pick) begin
                    t.wr    = bus.data_wr;
                    t.size  = bus.data_size;
                    t.addr  = bus.data_addr;
                    t.wstrb = bus.data_wr ? bus.data_wstrb : 4'h0;
                    t.wdata = bus.data_wdata;
                end else begin
                    t.wr    = 1'b0;
                    t.size  = 2'd2;
                    t.addr  = bus.inst_addr;
                    t.wstrb = 4'h0;
                    t.wdata = 32'h0;
                end
                q.push_back(t);
            end
            tick();
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        logic exp_d;
        //          is_data wr    size  addr          wstrb wdata         rdata         e_wr  e_sz  e_strb
        vecs[0] = '{1'b0, 1'b1, 2'd0, 32'hBFC0_0000, 4'hF, 32'h5555_5555, 32'h2408_0001, 1'b0, 2'd2, 4'h0};
        vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h8000_1003, 4'h8, 32'hAB00_0000, 32'h0000_0000, 1'b1, 2'd0, 4'h8};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h8000_2000, 4'hF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 2'd2, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 2'd1, 32'h8000_0402, 4'hC, 32'hBEEF_0000, 32'h0000_0000, 1'b1, 2'd1, 4'hC};
        vecs[4] = '{1'b1, 1'b1, 2'd3, 32'h8000_0010, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 2'd3, 4'hF};
        vecs[5] = '{1'b0, 1'b0, 2'd2, 32'h8000_0004, 4'h3, 32'h0000_0000, 32'h3C1D_8001, 1'b0, 2'd2, 4'h0};

        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        settle();
        check_zero("reset");
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) apply_vec(i, vecs[i]);

        // Tie with data dropping after its accept: data first, fetch next.
        do_reset();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0100;
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h0000_0200;
        serve(1'b1, 32'h0000_0200, 32'h1111_0001, 1'b0, "tie_a1");
        serve(1'b0, 32'h0000_0100, 32'h1111_0002, 1'b0, "tie_a2");

        // Both held continuously: fixed priority keeps data; round-robin alternates.
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_d = RR_MODE ? (g % 2 == 0) : 1'b1;
            serve(exp_d, exp_d ? 32'h0000_0200 : 32'h0000_0100, 32'h2222_0000 + 32'(g), 1'b1,
                  $sformatf("tie_b%0d", g));
        end
        clear_inputs();
        tick();

        // Accept stall with a stray data_ok, then a long response with a stray addr_ok.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1FC0_0010;
        settle();
        tick();
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h8000_0100;
        bus.data_size = 2'd2;
        for (int k = 0; k < 5; k++) begin
            bus.data_ok = (k == 2);
            settle();
            chk($sformatf("stall%0d req", k),     64'(bus.req),  64'(1));
            chk($sformatf("stall%0d addr", k),    64'(bus.addr), 64'(32'h1FC0_0010));
            chk($sformatf("stall%0d addr_ok", k), 64'({bus.inst_addr_ok, bus.data_addr_ok}), 64'(0));
            chk($sformatf("stall%0d data_ok", k), 64'({bus.inst_data_ok, bus.data_data_ok}), 64'(0));
            tick();
        end
        bus.data_ok = 1'b0;
        bus.addr_ok = 1'b1;
        settle();
        chk("stall accept inst_addr_ok", 64'(bus.inst_addr_ok), 64'(1));
        chk("stall accept data_addr_ok", 64'(bus.data_addr_ok), 64'(0));
        tick();
        bus.addr_ok  = 1'b0;
        bus.inst_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.addr_ok = (k == 3);
            settle();
            chk($sformatf("wait%0d req", k),     64'(bus.req), 64'(0));
            chk($sformatf("wait%0d addr_ok", k), 64'({bus.inst_addr_ok, bus.data_addr_ok}), 64'(0));
            chk($sformatf("wait%0d data_ok", k), 64'({bus.inst_data_ok, bus.data_data_ok}), 64'(0));
            tick();
        end
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b1;
        bus.rdata   = 32'h0BAD_F00D;
        settle();
        chk("wait resp inst_data_ok", 64'(bus.inst_data_ok), 64'(1));
        chk("wait resp data_data_ok", 64'(bus.data_data_ok), 64'(0));
        tick();
        bus.data_ok = 1'b0;
        serve(1'b1, 32'h8000_0100, 32'h1234_5678, 1'b0, "stall_next");

        // Stray handshakes while idle change nothing.
        clear_inputs();
        bus.data_ok = 1'b1;
        bus.addr_ok = 1'b1;
        settle();
        check_quiet("stray_idle");
        tick();
        bus.data_ok   = 1'b0;
        bus.addr_ok   = 1'b0;
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0380;
        serve(1'b0, 32'hBFC0_0380, 32'h4000_6800, 1'b0, "after_stray");

        // Reset while waiting for the response.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h8000_0200;
        settle();
        tick();
        bus.addr_ok = 1'b1;
        settle();
        chk("rst_mid req", 64'(bus.req), 64'(1));
        tick();
        clear_inputs();
        resetn = 1'b0;
        settle();
        chk("rst_mid resp req", 64'(bus.req), 64'(0));
        tick();
        resetn = 1'b1;
        settle();
        check_zero("rst_mid");
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h8000_0300;
        serve(1'b0, 32'h8000_0300, 32'h0000_0021, 1'b0, "after_rst");

        do_reset();
        run_random(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
